camera_sensor_emulator: RTL and testbench

CAMERA_SENSOR_EMULATOR -- requirements
Module: camera_sensor_emulator

---
 rtl/camera_sensor_emulator.sv | 203 ++++++++++++++++++++
 tb/tb_camera_sensor_emulator.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_sensor_emulator.sv
// Emulates a parallel CMOS sensor: FVAL/LVAL framing, pixel clock at Clock/2
// and a GRBG Bayer test pattern stream, with frame counting and start/stop control.
module camera_sensor_emulator #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 64,
  parameter int V_ACTIVE = 960,
  parameter int V_BLANK  = 8,
  parameter int F2L      = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stop,
  input  logic [1:0]  Pattern_sel,
  output logic        oPIXCLK,
  output logic        oFrame_Valid,
  output logic        oLine_Valid,
  output logic [9:0]  oData,
  output logic [31:0] oFrame_Count,
  output logic        oBusy
);

  localparam int FB_LEN  = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int MAX_A   = (FB_LEN > H_BLANK) ? FB_LEN : H_BLANK;
  localparam int CNT_MAX = (MAX_A > F2L) ? MAX_A : F2L;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int COL_W   = $clog2(H_ACTIVE + 1);
  localparam int ROW_W   = $clog2(V_ACTIVE + 1);

  localparam logic [CNT_W-1:0] F2L_LAST = CNT_W'(F2L - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] FB_LAST  = CNT_W'(FB_LEN - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE,
    F2L_WAIT,
    LINE_ACTIVE,
    LINE_BLANK,
    FRAME_BLANK
  } state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic              fval_q, fval_d;
  logic              lval_q, lval_d;
  logic [9:0]        data_q, data_d;
  logic [31:0]       frame_count_q, frame_count_d;
  logic              busy_q, busy_d;
  logic              stop_pend_q, stop_pend_d;
  logic [1:0]        pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  function automatic logic [9:0] pixel_value(input logic [COL_W-1:0] col,
                                             input logic [ROW_W-1:0] row,
                                             input logic [1:0]       pat,
                                             input logic             parity);
    logic [9:0] col10;
    logic [2:0] bar;
    logic       row_b4;
    logic       is_r, is_g, is_b;
    logic [9:0] v;
    col10  = 10'(col);
    bar    = 3'({col, 3'b000} / (COL_W + 3)'(H_ACTIVE));
    row_b4 = ((row >> 4) & ROW_W'(1)) != '0;
    is_g   = (col[0] == row[0]);
    is_r   = !row[0] && col[0];
    is_b   = row[0] && !col[0];
    case (pat)
      2'd0:    v = ((is_r && bar[2]) || (is_g && bar[1]) || (is_b && bar[0])) ? 10'h3FF : 10'h000;
      2'd1:    v = col10;
      2'd2:    v = (col10[4] ^ row_b4 ^ parity) ? 10'h3FF : 10'h000;
      default: v = is_r ? 10'h3FF : (is_g ? 10'h200 : 10'h000);
    endcase
    return v;
  endfunction

  // All framing state advances only when phase falls, so outputs are steady at oPIXCLK rise.
  always_comb begin
    state_d       = state_q;
    phase_d       = ~phase_q;
    fval_d        = fval_q;
    lval_d        = lval_q;
    data_d        = data_q;
    frame_count_d = frame_count_q;
    stop_pend_d   = stop_pend_q;
    pat_d         = pat_q;
    cnt_d         = cnt_q;
    col_d         = col_q;
    row_d         = row_q;

    if (state_q != IDLE && Stop) stop_pend_d = 1'b1;

    if (phase_q) begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_d     = F2L_WAIT;
            fval_d      = 1'b1;
            pat_d       = Pattern_sel;
            cnt_d       = '0;
            stop_pend_d = Stop;
          end
        end
        F2L_WAIT: begin
          if (cnt_q == F2L_LAST) begin
            state_d = LINE_ACTIVE;
            lval_d  = 1'b1;
            col_d   = '0;
            row_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LINE_ACTIVE: begin
          if (col_q == COL_LAST) begin
            lval_d = 1'b0;
            cnt_d  = '0;
            if (row_q == ROW_LAST) begin
              state_d       = FRAME_BLANK;
              fval_d        = 1'b0;
              frame_count_d = frame_count_q + 32'd1;
            end else begin
              state_d = LINE_BLANK;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        LINE_BLANK: begin
          if (cnt_q == HB_LAST) begin
            state_d = LINE_ACTIVE;
            lval_d  = 1'b1;
            col_d   = '0;
            row_d   = row_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FRAME_BLANK: begin
          if (cnt_q == FB_LAST) begin
            cnt_d = '0;
            if (stop_pend_q) begin
              state_d     = IDLE;
              stop_pend_d = 1'b0;
            end else begin
              state_d = F2L_WAIT;
              fval_d  = 1'b1;
              pat_d   = Pattern_sel;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      data_d = lval_d ? pixel_value(col_d, row_d, pat_d, frame_count_q[0]) : 10'h000;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      phase_q       <= 1'b0;
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      data_q        <= '0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      pat_q         <= '0;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      fval_q        <= fval_d;
      lval_q        <= lval_d;
      data_q        <= data_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      stop_pend_q   <= stop_pend_d;
      pat_q         <= pat_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
    end
  end

  assign oPIXCLK      = phase_q;
  assign oFrame_Valid = fval_q;
  assign oLine_Valid  = lval_q;
  assign oData        = data_q;
  assign oFrame_Count = frame_count_q;
  assign oBusy        = busy_q;

endmodule

// File: tb/tb_camera_sensor_emulator.sv
// Self-checking bench for camera_sensor_emulator: a scoreboard of expected pixels
// per frame plus a monitor that checks FVAL/LVAL framing once per pixel period.
module tb_camera_sensor_emulator;

  localparam int H_ACTIVE = 8;
  localparam int H_BLANK  = 4;
  localparam int V_ACTIVE = 4;
  localparam int V_BLANK  = 2;
  localparam int F2L      = 2;
  localparam int FB_LEN   = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int FVAL_LEN = F2L + V_ACTIVE * H_ACTIVE + (V_ACTIVE - 1) * H_BLANK;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        Stop;
  logic [1:0]  Pattern_sel;
  logic        oPIXCLK;
  logic        oFrame_Valid;
  logic        oLine_Valid;
  logic [9:0]  oData;
  logic [31:0] oFrame_Count;
  logic        oBusy;

  int assertCount = 0;
  int failCount   = 0;

  logic [9:0] sbQueue[$];

  camera_sensor_emulator #(
    .H_ACTIVE(H_ACTIVE),
    .H_BLANK (H_BLANK),
    .V_ACTIVE(V_ACTIVE),
    .V_BLANK (V_BLANK),
    .F2L     (F2L)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Stop        (Stop),
    .Pattern_sel (Pattern_sel),
    .oPIXCLK     (oPIXCLK),
    .oFrame_Valid(oFrame_Valid),
    .oLine_Valid (oLine_Valid),
    .oData       (oData),
    .oFrame_Count(oFrame_Count),
    .oBusy       (oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected pixel straight from the pattern definitions, GRBG Bayer order.
  function automatic logic [9:0] expPixel(input int col, input int row, input int pat, input int parity);
    int bar;
    bit isR, isB, isG;
    logic [9:0] v;
    isR = ((row % 2) == 0) && ((col % 2) == 1);
    isB = ((row % 2) == 1) && ((col % 2) == 0);
    isG = !isR && !isB;
    case (pat)
      0: begin
        bar = (col * 8) / H_ACTIVE;
        v = ((isR && ((bar >> 2) & 1) == 1) || (isG && ((bar >> 1) & 1) == 1) ||
             (isB && (bar & 1) == 1)) ? 10'h3FF : 10'h000;
      end
      1: v = 10'(col);
      2: v = ((((col >> 4) ^ (row >> 4) ^ parity) & 1) == 1) ? 10'h3FF : 10'h000;
      default: v = isR ? 10'h3FF : (isG ? 10'h200 : 10'h000);
    endcase
    return v;
  endfunction

  task automatic pushFrame(input int pat, input int parity);
    for (int r = 0; r < V_ACTIVE; r++)
      for (int c = 0; c < H_ACTIVE; c++)
        sbQueue.push_back(expPixel(c, r, pat, parity));
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic [1:0] pat, input int cycles);
    Start       = start;
    Stop        = stop;
    Pattern_sel = pat;
    repeat (cycles) @(negedge Clock);
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int k;
    k = 0;
    while (oBusy && k < maxCycles) begin
      @(negedge Clock);
      k++;
    end
    checkOutput("idle_reached", oBusy, 0);
  endtask

  task automatic waitFrameCount(input logic [31:0] value, input int maxCycles);
    int k;
    k = 0;
    while (oFrame_Count != value && k < maxCycles) begin
      @(negedge Clock);
      k++;
    end
    checkOutput("wait_fcount", oFrame_Count, value);
  endtask

  task automatic waitLvalRises(input int n, input int maxCycles);
    int rises;
    int k;
    logic prev;
    rises = 0;
    k     = 0;
    prev  = oLine_Valid;
    while (rises < n && k < maxCycles) begin
      @(negedge Clock);
      k++;
      if (oLine_Valid && !prev) rises++;
      prev = oLine_Valid;
    end
    checkOutput("wait_lval", rises, n);
  endtask

  // Monitor: one sample per pixel period, taken while oPIXCLK is high.
  int   framesSeen;
  int   fvalLen, lineLen, linesSeen, preLine, gapLen;
  logic fvalPrev, lvalPrev, inGap, rstPrev;
  initial begin
    logic [9:0] expData;
    rstPrev = 1'b0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        if (!rstPrev) sbQueue.delete();
        framesSeen = 0; fvalLen = 0; lineLen = 0; linesSeen = 0;
        preLine = 0; gapLen = 0; fvalPrev = 1'b0; lvalPrev = 1'b0; inGap = 1'b0;
      end else if (oPIXCLK) begin
        if (oLine_Valid) begin
          if (!lvalPrev) begin
            lineLen = 0;
            if (linesSeen == 0) checkOutput("f2l_len", preLine, F2L);
          end
          lineLen++;
          if (sbQueue.size() == 0) begin
            checkOutput("sb_empty", oLine_Valid, 0);
          end else begin
            expData = sbQueue.pop_front();
            checkOutput("pixel", oData, expData);
          end
        end else begin
          if (lvalPrev) begin
            checkOutput("line_len", lineLen, H_ACTIVE);
            linesSeen++;
          end
          checkOutput("data_blank", oData, 0);
        end
        if (!oFrame_Valid) checkOutput("lval_outside", oLine_Valid, 0);

        if (oFrame_Valid) begin
          if (!fvalPrev) begin
            if (inGap) checkOutput("frame_gap", gapLen, FB_LEN);
            fvalLen = 0; linesSeen = 0; preLine = 0; inGap = 1'b0;
          end
          fvalLen++;
          if (linesSeen == 0 && !oLine_Valid) preLine++;
        end else if (fvalPrev) begin
          checkOutput("fval_len", fvalLen, FVAL_LEN);
          checkOutput("line_count", linesSeen, V_ACTIVE);
          checkOutput("frame_count", oFrame_Count, framesSeen + 1);
          framesSeen++;
          inGap  = 1'b1;
          gapLen = 0;
        end
        if (inGap && !oFrame_Valid) begin
          if (oBusy) gapLen++;
          else inGap = 1'b0;
        end
        fvalPrev = oFrame_Valid;
        lvalPrev = oLine_Valid;
      end
      rstPrev = Reset;
    end
  end

  initial begin
    int   blankLen;
    int   k;
    Reset       = 1'b1;
    Start       = 1'b0;
    Stop        = 1'b0;
    Pattern_sel = 2'd0;
    repeat (3) @(negedge Clock);

    // Reset state
    checkOutput("rst_pixclk", oPIXCLK, 0);
    checkOutput("rst_fval", oFrame_Valid, 0);
    checkOutput("rst_lval", oLine_Valid, 0);
    checkOutput("rst_data", oData, 0);
    checkOutput("rst_fcount", oFrame_Count, 0);
    checkOutput("rst_busy", oBusy, 0);

    // Ramp frame; first pixel update lands on the second edge after release
    pushFrame(1, 0);
    Reset       = 1'b0;
    Start       = 1'b1;
    Pattern_sel = 2'd1;
    @(posedge Clock); #1;
    checkOutput("edge1_pixclk", oPIXCLK, 1);
    checkOutput("edge1_fval", oFrame_Valid, 0);
    @(posedge Clock); #1;
    checkOutput("edge2_pixclk", oPIXCLK, 0);
    checkOutput("edge2_fval", oFrame_Valid, 1);
    checkOutput("edge2_busy", oBusy, 1);
    Start = 1'b0;
    @(negedge Clock);
    applyStimulus(1'b0, 1'b1, 2'd1, 1);
    waitIdle(1000);
    checkOutput("ramp_fcount", oFrame_Count, 1);
    checkOutput("ramp_drained", sbQueue.size(), 0);

    // Flat pattern with Start and Stop together in IDLE: one frame only
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    pushFrame(3, 0);
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd3, 2);
    checkOutput("flat_busy", oBusy, 1);
    waitIdle(1000);
    checkOutput("flat_fcount", oFrame_Count, 1);
    repeat (60) @(negedge Clock);
    checkOutput("flat_no_restart", oBusy, 0);
    checkOutput("flat_drained", sbQueue.size(), 0);

    // Checker over three frames, Stop during row 1 of frame 3
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    pushFrame(2, 0);
    pushFrame(2, 1);
    pushFrame(2, 0);
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd2, 2);
    waitFrameCount(2, 1000);
    waitLvalRises(2, 200);
    applyStimulus(1'b0, 1'b1, 2'd2, 1);
    k = 0;
    while (!(oFrame_Count == 3 && oPIXCLK) && k < 400) begin
      @(negedge Clock);
      k++;
    end
    checkOutput("stop_fcount3", oFrame_Count, 3);
    blankLen = oBusy ? 1 : 0;
    k = 0;
    while (k < 200) begin
      @(negedge Clock);
      k++;
      if (oPIXCLK) begin
        if (oBusy) blankLen++;
        else break;
      end
    end
    checkOutput("stop_blank_len", blankLen, FB_LEN);
    checkOutput("stop_busy", oBusy, 0);
    checkOutput("stop_fcount", oFrame_Count, 3);
    checkOutput("stop_drained", sbQueue.size(), 0);

    // Pattern change mid-frame: bars stay, ramp from the next frame
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    pushFrame(0, 0);
    pushFrame(1, 1);
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0, 2);
    waitLvalRises(1, 100);
    repeat (3) @(negedge Clock);
    Pattern_sel = 2'd1;
    waitFrameCount(1, 1000);
    k = 0;
    while (!oFrame_Valid && k < 200) begin
      @(negedge Clock);
      k++;
    end
    checkOutput("sel_frame2_fval", oFrame_Valid, 1);
    applyStimulus(1'b0, 1'b1, 2'd1, 1);
    waitIdle(1000);
    checkOutput("sel_fcount", oFrame_Count, 2);
    checkOutput("sel_drained", sbQueue.size(), 0);

    // Reset during LINE_ACTIVE, then restart from row 0 column 0
    pushFrame(1, 0);
    applyStimulus(1'b1, 1'b0, 2'd1, 2);
    waitLvalRises(2, 200);
    repeat (5) @(negedge Clock);
    checkOutput("pre_rst_lval", oLine_Valid, 1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    checkOutput("mid_rst_pixclk", oPIXCLK, 0);
    checkOutput("mid_rst_fval", oFrame_Valid, 0);
    checkOutput("mid_rst_lval", oLine_Valid, 0);
    checkOutput("mid_rst_data", oData, 0);
    checkOutput("mid_rst_fcount", oFrame_Count, 0);
    checkOutput("mid_rst_busy", oBusy, 0);
    repeat (3) @(negedge Clock);
    pushFrame(3, 0);
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd3, 2);
    applyStimulus(1'b0, 1'b1, 2'd3, 1);
    waitIdle(1000);
    checkOutput("restart_fcount", oFrame_Count, 1);
    checkOutput("restart_drained", sbQueue.size(), 0);

    repeat (4) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
